// File: rtl/alu_op_if.sv
// Bundle between the main controller and the ALU control decoder:
// class/function inputs and the registered operation select.
interface alu_op_if;
    logic [5:0] func;
    logic [1:0] ALUctr;
    logic [2:0] ALU_op;
    logic       illegal;

    modport master (
        output func,
        output ALUctr,
        input  ALU_op,
        input  illegal
    );

    modport slave (
        input  func,
        input  ALUctr,
        output ALU_op,
        output illegal
    );
endinterface

// File: rtl/alu_op.sv
// ALU control decoder: maps (ALUctr, func) to a 3-bit ALU operation select,
// flags unsupported R-type functions, and registers both with one cycle latency.
module alu_op (
    input logic     clk,
    input logic     rst,
    alu_op_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SLT = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_OR    = 2'b11
    } class_e;

    op_e  op_next;
    logic illegal_next;
    op_e  op_q;
    logic illegal_q;

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves
        // a signal unassigned and no latch is inferred.
        op_next      = OP_ADD;
        illegal_next = 1'b0;
        case (class_e'(bus.ALUctr))
            CLS_ADD: op_next = OP_ADD;
            CLS_SUB: op_next = OP_SUB;
            CLS_OR:  op_next = OP_OR;
            CLS_RTYPE: begin
                case (bus.func)
                    6'b100000, 6'b100001: op_next = OP_ADD;
                    6'b100010, 6'b100011: op_next = OP_SUB;
                    6'b100100:            op_next = OP_AND;
                    6'b100101:            op_next = OP_OR;
                    6'b100110:            op_next = OP_XOR;
                    6'b100111:            op_next = OP_NOR;
                    6'b101010:            op_next = OP_SLT;
                    // Unsupported function: fall back to ADD and raise the flag.
                    default: begin
                        op_next      = OP_ADD;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            default: begin
                op_next      = OP_ADD;
                illegal_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its input from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_ADD;
            illegal_q <= 1'b0;
        end else begin
            op_q      <= op_next;
            illegal_q <= illegal_next;
        end
    end

    assign bus.ALU_op  = op_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_op.sv
// Self-checking bench for alu_op: reset/latency hand sequences, a directed
// vector table and an exhaustive sweep, all compared through a scoreboard queue.
module tb_alu_op;

    typedef struct {
        logic [5:0] func;
        logic [1:0] ctr;
        logic [2:0] op;
        logic       ill;
        string      name;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic       ill;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];

    alu_op_if bus ();

    alu_op dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Independent reference decode written straight from the encoding tables.
    function automatic void ref_dec(input logic [5:0] f, input logic [1:0] c,
                                    output logic [2:0] op, output logic ill);
        ill = 1'b0;
        op  = 3'b000;
        if (c == 2'b00)      op = 3'b000;
        else if (c == 2'b01) op = 3'b001;
        else if (c == 2'b11) op = 3'b011;
        else begin
            case (f)
                6'h20, 6'h21: op = 3'b000;
                6'h22, 6'h23: op = 3'b001;
                6'h24:        op = 3'b010;
                6'h25:        op = 3'b011;
                6'h26:        op = 3'b100;
                6'h27:        op = 3'b101;
                6'h2a:        op = 3'b110;
                default: begin
                    op  = 3'b000;
                    ill = 1'b1;
                end
            endcase
        end
    endfunction

    task automatic compare_pending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_op"},  {5'b0, bus.ALU_op},  {5'b0, e.op});
            check({e.name, "_ill"}, {7'b0, bus.illegal}, {7'b0, e.ill});
            check({e.name, "_not111"}, {7'b0, bus.ALU_op != 3'b111}, 8'd1);
        end
    endtask

    // Compare the result of the previous drive, then drive new inputs and queue their expectation.
    task automatic send(input logic [5:0] f, input logic [1:0] c,
                        input logic [2:0] op, input logic ill, input string name);
        @(negedge clk);
        compare_pending();
        bus.func   = f;
        bus.ALUctr = c;
        sb.push_back('{op: op, ill: ill, name: name});
    endtask

    task automatic drain();
        @(negedge clk);
        compare_pending();
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0] rop;
        logic       rill;

        vecs = '{
            '{6'b100000, 2'b10, 3'b000, 1'b0, "r_add"},
            '{6'b100010, 2'b10, 3'b001, 1'b0, "r_sub"},
            '{6'b100100, 2'b10, 3'b010, 1'b0, "r_and"},
            '{6'b100101, 2'b10, 3'b011, 1'b0, "r_or"},
            '{6'b100110, 2'b10, 3'b100, 1'b0, "r_xor"},
            '{6'b100111, 2'b10, 3'b101, 1'b0, "r_nor"},
            '{6'b101010, 2'b10, 3'b110, 1'b0, "r_slt"},
            '{6'b100001, 2'b10, 3'b000, 1'b0, "r_addu"},
            '{6'b100011, 2'b10, 3'b001, 1'b0, "r_subu"},
            '{6'b000000, 2'b00, 3'b000, 1'b0, "c00_f0"},
            '{6'b000000, 2'b01, 3'b001, 1'b0, "c01_f0"},
            '{6'b000000, 2'b11, 3'b011, 1'b0, "c11_f0"},
            '{6'b100110, 2'b00, 3'b000, 1'b0, "c00_fxor"},
            '{6'b100110, 2'b01, 3'b001, 1'b0, "c01_fxor"},
            '{6'b100110, 2'b11, 3'b011, 1'b0, "c11_fxor"},
            '{6'b111111, 2'b01, 3'b001, 1'b0, "c01_fbad"},
            '{6'b000000, 2'b10, 3'b000, 1'b1, "ill_000000"},
            '{6'b111111, 2'b10, 3'b000, 1'b1, "ill_111111"},
            '{6'b100100, 2'b10, 3'b010, 1'b0, "after_ill_and"}
        };

        bus.func   = 6'b0;
        bus.ALUctr = 2'b0;
        repeat (2) @(negedge clk);

        // Reset value while held, across an edge.
        check("reset_init_op",  {5'b0, bus.ALU_op},  8'd0);
        check("reset_init_ill", {7'b0, bus.illegal}, 8'd0);
        rst = 1'b0;

        // Preload a non-zero op, then assert reset between edges.
        @(negedge clk);
        bus.func = 6'b100101; bus.ALUctr = 2'b10;
        @(posedge clk); #1;
        check("preload_or", {5'b0, bus.ALU_op}, 8'd3);
        @(negedge clk);
        bus.func = 6'b100010; bus.ALUctr = 2'b10;
        rst = 1'b1;
        #1;
        check("async_reset_op",  {5'b0, bus.ALU_op},  8'd0);
        check("async_reset_ill", {7'b0, bus.illegal}, 8'd0);
        @(posedge clk); #1;
        check("reset_hold_op", {5'b0, bus.ALU_op}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release_op",  {5'b0, bus.ALU_op},  8'd1);
        check("reset_release_ill", {7'b0, bus.illegal}, 8'd0);

        // Capture illegal=1, then reset mid-cycle with an illegal decode pending.
        @(negedge clk);
        bus.func = 6'b000000; bus.ALUctr = 2'b10;
        @(posedge clk); #1;
        check("preload_ill", {7'b0, bus.illegal}, 8'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_clear_ill", {7'b0, bus.illegal}, 8'd0);
        @(posedge clk); #1;
        check("discard_pending_ill", {7'b0, bus.illegal}, 8'd0);
        check("discard_pending_op",  {5'b0, bus.ALU_op},  8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table through the scoreboard.
        foreach (vecs[i]) send(vecs[i].func, vecs[i].ctr, vecs[i].op, vecs[i].ill, vecs[i].name);
        drain();

        // Latency/hold: a mid-cycle input change must not reach the outputs before the edge.
        @(negedge clk);
        bus.func = 6'b100000; bus.ALUctr = 2'b10;
        @(posedge clk); #1;
        check("hold_first", {5'b0, bus.ALU_op}, 8'd0);
        #2;
        bus.func = 6'b100101;
        #2;
        check("hold_midcycle", {5'b0, bus.ALU_op}, 8'd0);
        @(posedge clk); #1;
        check("hold_next_edge", {5'b0, bus.ALU_op}, 8'd3);

        // Exhaustive sweep against the reference decode.
        for (int c = 0; c < 4; c++) begin
            for (int f = 0; f < 64; f++) begin
                ref_dec(6'(f), 2'(c), rop, rill);
                send(6'(f), 2'(c), rop, rill, $sformatf("sweep_c%0d_f%0d", c, f));
            end
        end
        drain();

        check("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
